note_mix_pipeline: RTL and testbench

//  Parametrised, pipelined voice mixer; replaces the single-cycle note summer.
//  On each sample_tick it snapshots every enabled channel's shaped note word.

---
 rtl/note_mix_pipeline_pkg.sv | 40 ++++
 rtl/note_mix_pipeline_add_tree_stage.sv | 40 ++++
 rtl/note_mix_pipeline.sv | 135 +++++++++++++
 tb/tb_note_mix_pipeline.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_mix_pipeline_pkg.sv
// Shared helpers for the pipelined voice mixer: sizing, popcount and output clamping.
package note_mix_pipeline_pkg;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) c = c + 7'(v[i]);
    return c;
  endfunction

  // Clamp a sign-extended sum into an nbo-bit signed or unsigned range.
  function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v,
                                                        input int unsigned nbo,
                                                        input logic is_signed);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    if (is_signed) begin
      hi = (64'sd1 <<< (nbo - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (nbo - 1));
    end else begin
      hi = (64'sd1 <<< nbo) - 64'sd1;
      lo = 64'sd0;
    end
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/note_mix_pipeline_add_tree_stage.sv
// One registered level of the mixer adder tree: N_IN words in, N_IN/2 pairwise sums out.
module note_mix_pipeline_add_tree_stage #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [N_IN*W-1:0]     in_data,
  output logic                  out_valid,
  output logic [(N_IN/2)*W-1:0] out_data
);

  localparam int unsigned N_OUT = N_IN / 2;

  logic [N_OUT*W-1:0] sum_d, sum_q;
  logic               valid_d, valid_q;

  always_comb begin
    sum_d   = '0;
    valid_d = in_valid;
    for (int i = 0; i < N_OUT; i++) begin
      sum_d[i*W +: W] = in_data[(2*i)*W +: W] + in_data[(2*i+1)*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = sum_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/note_mix_pipeline.sv
// Pipelined voice mixer: tick-sampled capture, registered adder tree, shift/saturate,
// and a valid/ready output register with a sticky overrun flag.
module note_mix_pipeline
  import note_mix_pipeline_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned NUM_BITS_IN  = 18,
  parameter int unsigned NUM_BITS_OUT = 24,
  parameter int unsigned SIGNED_IN    = 1,
  parameter int unsigned SHIFT_BITS   = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_tick,
  input  logic [NUM_CHANNELS*NUM_BITS_IN-1:0] notes_in,
  input  logic [NUM_CHANNELS-1:0]             chan_en,
  input  logic [SHIFT_BITS-1:0]               gain_shift,
  input  logic                                out_ready,
  input  logic                                clear_ovr,
  output logic [NUM_BITS_OUT-1:0]             note_out,
  output logic                                out_valid,
  output logic [clog2(NUM_CHANNELS):0]        active_cnt,
  output logic                                overrun
);

  localparam int unsigned L  = clog2(NUM_CHANNELS);
  localparam int unsigned SW = NUM_BITS_IN + L + 1;
  localparam int unsigned CW = L + 1;

  logic [NUM_CHANNELS*SW-1:0]     cap_d, cap_q;
  logic                           cap_vld_d, cap_vld_q;
  logic [CW-1:0]                  act_d, act_q;
  logic [NUM_CHANNELS-1:0]        nz;
  logic [NUM_BITS_IN-1:0]         word;
  logic [SW-1:0]                  ext;
  logic [(2*NUM_CHANNELS-1)*SW-1:0] tree_data;
  logic [L:0]                     tree_vld;
  logic signed [SW-1:0]           shifted;
  logic signed [MAX_W-1:0]        wide;
  logic [NUM_BITS_OUT-1:0]        scl_d, scl_q;
  logic                           scl_vld_d, scl_vld_q;
  logic [NUM_BITS_OUT-1:0]        note_d, note_q;
  logic                           out_vld_d, out_vld_q;
  logic                           ovr_d, ovr_q;

  // Capture: masked, width-extended channel words and the active-voice count.
  always_comb begin
    cap_d     = cap_q;
    cap_vld_d = sample_tick;
    act_d     = act_q;
    nz        = '0;
    word      = '0;
    ext       = '0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      word  = notes_in[j*NUM_BITS_IN +: NUM_BITS_IN];
      ext   = (SIGNED_IN != 0) ? {{(SW-NUM_BITS_IN){word[NUM_BITS_IN-1]}}, word}
                               : {{(SW-NUM_BITS_IN){1'b0}}, word};
      nz[j] = chan_en[j] && (word != '0);
      if (sample_tick) cap_d[j*SW +: SW] = chan_en[j] ? ext : '0;
    end
    if (sample_tick) act_d = CW'(popcount(MAX_W'(nz)));
  end

  // Tree levels packed into one vector: level k starts at node 2N - 2*(N>>k).
  assign tree_data[NUM_CHANNELS*SW-1:0] = cap_q;
  assign tree_vld[0]                    = cap_vld_q;

  for (genvar k = 0; k < L; k++) begin : g_tree
    localparam int unsigned N_IN    = NUM_CHANNELS >> k;
    localparam int unsigned OFF_IN  = 2*NUM_CHANNELS - 2*N_IN;
    localparam int unsigned OFF_OUT = OFF_IN + N_IN;
    note_mix_pipeline_add_tree_stage #(.N_IN(N_IN), .W(SW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (tree_vld[k]),
      .in_data   (tree_data[OFF_IN*SW +: N_IN*SW]),
      .out_valid (tree_vld[k+1]),
      .out_data  (tree_data[OFF_OUT*SW +: (N_IN/2)*SW])
    );
  end

  // Scale and clamp the root sum; gain_shift is taken live at this stage.
  always_comb begin
    shifted   = $signed(tree_data[(2*NUM_CHANNELS-2)*SW +: SW]) >>> gain_shift;
    wide      = {{(MAX_W-SW){shifted[SW-1]}}, shifted};
    scl_d     = NUM_BITS_OUT'(saturate(wide, NUM_BITS_OUT, SIGNED_IN != 0));
    scl_vld_d = tree_vld[L];
  end

  // Output handshake: a held, unaccepted sample wins over a newly arriving one.
  always_comb begin
    note_d    = note_q;
    out_vld_d = out_vld_q;
    ovr_d     = ovr_q;
    if (clear_ovr) ovr_d = 1'b0;
    if (scl_vld_q) begin
      if (out_vld_q && !out_ready) begin
        ovr_d = 1'b1;
      end else begin
        note_d    = scl_q;
        out_vld_d = 1'b1;
      end
    end else if (out_vld_q && out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      act_q     <= '0;
      scl_q     <= '0;
      scl_vld_q <= 1'b0;
      note_q    <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      act_q     <= act_d;
      scl_q     <= scl_d;
      scl_vld_q <= scl_vld_d;
      note_q    <= note_d;
      out_vld_q <= out_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign note_out   = note_q;
  assign out_valid  = out_vld_q;
  assign active_cnt = act_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_note_mix_pipeline.sv
// Scoreboard bench for note_mix_pipeline: default instance plus an 18-bit-output instance for clamping.
module tb_note_mix_pipeline;

  localparam int unsigned N   = 16;
  localparam int unsigned NBI = 18;
  localparam int unsigned NBO = 24;
  localparam int unsigned SB  = 3;
  localparam int unsigned CW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           sample_tick, tick18;
  logic [N*NBI-1:0] notes_in;
  logic [N-1:0]   chan_en;
  logic [SB-1:0]  gain_shift;
  logic           out_ready, ready18, clear_ovr;

  logic [NBO-1:0] note_out;
  logic           out_valid;
  logic [CW-1:0]  active_cnt;
  logic           overrun;
  logic [17:0]    note18;
  logic           vld18;
  logic [CW-1:0]  act18;
  logic           ovr18;

  int checks   = 0;
  int failures = 0;
  logic [NBO-1:0] exp_q[$];
  logic [17:0]    exp18_q[$];

  always #5 clk = ~clk;

  note_mix_pipeline dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .notes_in(notes_in),
    .chan_en(chan_en), .gain_shift(gain_shift), .out_ready(out_ready),
    .clear_ovr(clear_ovr), .note_out(note_out), .out_valid(out_valid),
    .active_cnt(active_cnt), .overrun(overrun)
  );

  note_mix_pipeline #(.NUM_BITS_OUT(18)) dut18 (
    .clk(clk), .rst(rst), .sample_tick(tick18), .notes_in(notes_in),
    .chan_en(chan_en), .gain_shift(gain_shift), .out_ready(ready18),
    .clear_ovr(clear_ovr), .note_out(note18), .out_valid(vld18),
    .active_cnt(act18), .overrun(ovr18)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a transfer is seen at the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got 0x%0h with no expected entry at %0t", note_out, $time);
      end else begin
        check("note_out", 64'(note_out), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && vld18 && ready18) begin
      if (exp18_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample18: got 0x%0h with no expected entry at %0t", note18, $time);
      end else begin
        check("note_out18", 64'(note18), 64'(exp18_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_all(input logic [NBI-1:0] v);
    for (int j = 0; j < N; j++) notes_in[j*NBI +: NBI] = v;
  endtask

  task automatic do_tick(input logic is18);
    if (is18) tick18 = 1'b1;
    else sample_tick = 1'b1;
    @(posedge clk);
    #2;
    sample_tick = 1'b0;
    tick18      = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || exp18_q.size() != 0); i++) step(1);
    check("queue_drained", 64'(exp_q.size() + exp18_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; sample_tick = 1'b0; tick18 = 1'b0; notes_in = '0; chan_en = '0;
    gain_shift = '0; out_ready = 1'b1; ready18 = 1'b1; clear_ovr = 1'b0;
    step(3);
    check("rst_note_out", 64'(note_out), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_active_cnt", 64'(active_cnt), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_out_valid18", 64'(vld18), 64'd0);
    rst = 1'b1;
    step(2);

    // Reset mid-mix: the in-flight token must vanish.
    set_all(18'h00100); chan_en = '1;
    do_tick(1'b0);
    check("t1_active_after_tick", 64'(active_cnt), 64'd16);
    step(2);
    rst = 1'b0;
    #1;
    check("t1_active_in_reset", 64'(active_cnt), 64'd0);
    step(2);
    rst = 1'b1;
    for (int c = 5; c <= 20; c++) begin
      step(1);
      check("t1_no_valid", 64'(out_valid), 64'd0);
    end
    check("t1_note_out", 64'(note_out), 64'd0);
    check("t1_active_cnt", 64'(active_cnt), 64'd0);
    check("t1_overrun", 64'(overrun), 64'd0);

    // Latency and plain sum: 0+1+...+15.
    for (int j = 0; j < N; j++) notes_in[j*NBI +: NBI] = NBI'(j);
    chan_en = '1;
    exp_q.push_back(24'd120);
    do_tick(1'b0);
    check("t2_active_cnt", 64'(active_cnt), 64'd15);
    for (int e = 1; e <= 5; e++) begin
      step(1);
      check("t2_not_yet_valid", 64'(out_valid), 64'd0);
    end
    step(1);
    check("t2_valid_at_6", 64'(out_valid), 64'd1);
    drain();

    // Negative word with channel mask.
    set_all(18'd7);
    notes_in[0 +: NBI]   = 18'h3FFFB;
    notes_in[NBI +: NBI] = 18'd3;
    chan_en = 16'h0003;
    exp_q.push_back(24'hFFFFFE);
    do_tick(1'b0);
    check("t3_active_cnt", 64'(active_cnt), 64'd2);
    drain();

    // Back-to-back ticks on ch0.
    set_all('0); chan_en = 16'h0001;
    for (int v = 1; v <= 4; v++) begin
      notes_in[0 +: NBI] = NBI'(v);
      exp_q.push_back(NBO'(v));
      sample_tick = 1'b1;
      step(1);
    end
    sample_tick = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t5_valid_run", 64'(out_valid), 64'd1);
    end
    step(1);
    check("t5_valid_drop", 64'(out_valid), 64'd0);
    drain();

    // Backpressure: second result is dropped and flagged.
    out_ready = 1'b0;
    notes_in[0 +: NBI] = 18'd10;
    exp_q.push_back(24'd10);
    do_tick(1'b0);
    step(1);
    notes_in[0 +: NBI] = 18'd20;
    do_tick(1'b0);
    step(8);
    check("t6_held_valid", 64'(out_valid), 64'd1);
    check("t6_held_note", 64'(note_out), 64'd10);
    check("t6_overrun_set", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    step(1);
    check("t6_valid_after_xfer", 64'(out_valid), 64'd0);
    check("t6_overrun_sticky", 64'(overrun), 64'd1);
    clear_ovr = 1'b1;
    step(1);
    clear_ovr = 1'b0;
    check("t6_overrun_cleared", 64'(overrun), 64'd0);
    drain();

    // Saturation on the 18-bit output instance.
    chan_en = '1; gain_shift = 3'd0;
    set_all(18'h1FFFF);
    exp18_q.push_back(18'h1FFFF);
    do_tick(1'b1);
    drain();
    set_all(18'h20000);
    exp18_q.push_back(18'h20000);
    do_tick(1'b1);
    drain();
    gain_shift = 3'd4;
    set_all(18'h1FFFF);
    exp18_q.push_back(18'h1FFFF);
    do_tick(1'b1);
    drain();
    check("t4_overrun18", 64'(ovr18), 64'd0);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
